// File: rtl/pipe_forward_hazard_unit.sv
// EX-stage operand forwarding, load-use hazard detection with a latency-sized
// stall FSM, and saturating stall/forward performance counters.
module pipe_forward_hazard_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_SRC      = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] IFID_Src,
  input  logic [NUM_SRC-1:0]            IFID_SrcUsed,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] IDEX_Src,
  input  logic                          IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0]         IDEX_RegisterRd,
  input  logic                          EXMEM_RegWrite,
  input  logic [REG_ADDR_W-1:0]         EXMEM_RegisterRd,
  input  logic                          MEMWB_RegWrite,
  input  logic [REG_ADDR_W-1:0]         MEMWB_RegisterRd,
  input  logic                          flush,
  output logic [NUM_SRC*2-1:0]          forward,
  output logic                          stall,
  output logic                          bubble,
  output logic [CNT_W-1:0]              stall_count,
  output logic [CNT_W-1:0]              fwd_count
);

  localparam int SCNT_W = $clog2(LOAD_LATENCY + 1);
  localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(LOAD_LATENCY - 1);
  localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic {IDLE, STALL} fsmState;

  fsmState           state, nextState;
  logic [SCNT_W-1:0] scnt, nextScnt;
  logic              hazard;
  logic              stallRaw;

  // Each operand resolves on its own; the EX/MEM check wins over MEM/WB.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    forward = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (EXMEM_RegWrite && EXMEM_RegisterRd != '0 &&
          EXMEM_RegisterRd == IDEX_Src[i*REG_ADDR_W +: REG_ADDR_W])
        forward[2*i +: 2] = 2'b10;
      else if (MEMWB_RegWrite && MEMWB_RegisterRd != '0 &&
               MEMWB_RegisterRd == IDEX_Src[i*REG_ADDR_W +: REG_ADDR_W])
        forward[2*i +: 2] = 2'b01;
    end
  end

  always_comb begin
    hazard = 1'b0;
    if (IDEX_MemRead && IDEX_RegisterRd != '0) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (IFID_SrcUsed[i] && IFID_Src[i*REG_ADDR_W +: REG_ADDR_W] == IDEX_RegisterRd)
          hazard = 1'b1;
      end
    end
  end

  // The detecting cycle is the first stall cycle; STALL covers the remaining
  // LOAD_LATENCY-1 cycles and ignores the hazard input meanwhile.
  always_comb begin
    nextState = state;
    nextScnt  = scnt;
    stallRaw  = 1'b0;
    case (state)
      IDLE: begin
        if (hazard && !flush) begin
          stallRaw = 1'b1;
          if (LOAD_LATENCY > 1) begin
            nextState = STALL;
            nextScnt  = SCNT_LOAD;
          end
        end
      end
      STALL: begin
        if (flush) begin
          nextState = IDLE;
        end else begin
          stallRaw = 1'b1;
          nextScnt = scnt - SCNT_ONE;
          if (scnt == SCNT_ONE) nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign stall  = stallRaw && !reset;
  assign bubble = stall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      scnt        <= '0;
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      state <= nextState;
      scnt  <= nextScnt;
      if (stall && stall_count != '1) stall_count <= stall_count + CNT_ONE;
      if (|forward && fwd_count != '1) fwd_count <= fwd_count + CNT_ONE;
    end
  end

endmodule

// File: doc/pipe_forward_hazard_unit.md
Name: pipe_forward_hazard_unit

Overview:
Parametrised successor to the pipeline ALU forwarding logic. Generates per-operand EX-stage forwarding selects with independent priority, and detects load-use hazards in ID. For load-use hazards it runs a multi-cycle stall FSM sized for variable load latency. It also keeps saturating performance counters. It sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and drives PC/IFID hold, the IDEX bubble, and the EX operand muxes.

Parameters:
REG_ADDR_W, 5, register address width
NUM_SRC, 2, number of source operands per instruction (Rs, Rt, ...)
LOAD_LATENCY, 1, stall cycles per load-use hazard (>=1)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
IFID_Src  in  NUM_SRC*REG_ADDR_W  ID-stage source regs, operand i at [i*REG_ADDR_W +: REG_ADDR_W]
IFID_SrcUsed  in  NUM_SRC  per-operand valid; unused operands never cause a stall
IDEX_Src  in  NUM_SRC*REG_ADDR_W  EX-stage source regs, same packing
IDEX_MemRead  in  1  instruction in EX is a load
IDEX_RegisterRd  in  REG_ADDR_W  destination of instruction in EX
EXMEM_RegWrite  in  1  MEM-stage writes a register
EXMEM_RegisterRd  in  REG_ADDR_W  MEM-stage destination
MEMWB_RegWrite  in  1  WB-stage writes a register
MEMWB_RegisterRd  in  REG_ADDR_W  WB-stage destination
flush  in  1  branch/jump flush; aborts any stall
forward  out  NUM_SRC*2  per-operand select at [2i +: 2]: 00 regfile, 10 EX/MEM, 01 MEM/WB
stall  out  1  hold PC and IF/ID
bubble  out  1  zero ID/EX control
stall_count  out  CNT_W  cycles with stall=1, saturating
fwd_count  out  CNT_W  cycles with any forward!=00, saturating

Behaviour:
- Forwarding is combinational and evaluated independently per operand i; no cross-operand coupling.
  - EX match: EXMEM_RegWrite && EXMEM_RegisterRd!=0 && EXMEM_RegisterRd==IDEX_Src[i] -> 10.
  - Else MEM match: same conditions with MEMWB fields -> 01.
  - Else 00.
  - EX always has priority over MEM when both match the same operand.
- Hazard (combinational): IDEX_MemRead && IDEX_RegisterRd!=0 && some i has IFID_SrcUsed[i] && IFID_Src[i]==IDEX_RegisterRd.
- FSM states: IDLE, STALL. Counter scnt is REG width clog2(LOAD_LATENCY+1).
  - IDLE: stall=bubble=hazard && !flush.
    - If hazard && !flush && LOAD_LATENCY>1: go to STALL, scnt<=LOAD_LATENCY-1.
    - Otherwise stay in IDLE. With LOAD_LATENCY=1 the stall lasts exactly one cycle.
  - STALL: stall=bubble=1; hazard input is ignored; scnt decrements each cycle.
    - When scnt==1 at the clock edge: return to IDLE.
    - Total stall length is exactly LOAD_LATENCY cycles.
  - flush in any state: stall=bubble=0 that cycle; next state IDLE.
- reset (sync) has priority over everything.
  - Reset values: state=IDLE, scnt=0, stall_count=0, fwd_count=0.
  - While reset=1, stall=0 and bubble=0. forward remains combinational.
  - Reset mid-stall drops to IDLE on the next edge.
- Counters:
  - stall_count increments on edges where stall=1.
  - fwd_count increments on edges where forward!=0.
  - Both hold at 2^CNT_W-1; they never wrap.
- Register 0 is never a forwarding source or hazard destination.

Test Plan:
1. NUM_SRC=2. EXMEM_RegWrite=1, EXMEM_Rd=5, MEMWB_RegWrite=1, MEMWB_Rd=5, IDEX_Src={Rt=7, Rs=5} -> forward[1:0]=10, forward[3:2]=00. Then MEMWB_Rd=7 -> forward[3:2]=01, forward[1:0] stays 10 (independent operands).
2. EXMEM_Rd=0 and MEMWB_Rd=0 with RegWrite=1, IDEX_Src all zero -> forward=0000, and fwd_count does not increment.
3. LOAD_LATENCY=1: IDEX_MemRead=1, IDEX_Rd=3, IFID_Src Rs=3, SrcUsed=01 -> stall=bubble=1 for exactly 1 cycle, stall_count=1. Same case with SrcUsed=00 -> no stall.
4. LOAD_LATENCY=3: hazard in cycle 0, hazard inputs deasserted in cycle 1 -> stall high in cycles 0-2, low in cycle 3, stall_count=3.
5. LOAD_LATENCY=3: stall begins, flush=1 in cycle 1 -> stall=0 in cycle 1 and FSM is IDLE at cycle 2. Repeat with reset=1 in cycle 1 -> stall=0 from cycle 1 and all counters=0.
6. CNT_W=4: hold an EX forward for 20 cycles -> fwd_count reaches 15 and stays at 15.
